// File: rtl/time_keeper.sv
// time_keeper: 1 Hz prescaler plus binary HH:MM:SS counter with debounced
// manual-adjust buttons and a RUN/SET mode switch. All state is on the rising
// edge of clock. reset_n clears everything asynchronously.
module time_keeper #(
    parameter int CLK_HZ          = 50_000_000,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        seconds_m,
    input  logic        minutes_m,
    input  logic        hours_m,
    input  logic        clock_m,
    output logic [25:0] tick,
    output logic [5:0]  seconds,
    output logic [5:0]  minutes,
    output logic [4:0]  hours,
    output logic        sec_pulse
);

    localparam int              NBTN      = 4;
    localparam int              DB_W      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [25:0]     TICK_LAST = 26'(CLK_HZ - 1);

    typedef enum logic {
        MODE_RUN = 1'b0,
        MODE_SET = 1'b1
    } mode_t;

    // Bit order: 0 = seconds, 1 = minutes, 2 = hours, 3 = run/set switch.
    logic [NBTN-1:0] raw;
    logic [NBTN-1:0] level;
    logic [2:0]      level_d_reg;
    logic [2:0]      inc_pulse;

    assign raw = {clock_m, hours_m, minutes_m, seconds_m};

    generate
        for (genvar gi = 0; gi < NBTN; gi++) begin : g_btn
            logic            sync1_reg;
            logic            sync2_reg;
            logic            level_reg;
            logic [DB_W-1:0] count_reg;

            // Two-flop synchroniser for the asynchronous raw input.
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    sync1_reg <= 1'b0;
                    sync2_reg <= 1'b0;
                end else begin
                    sync1_reg <= raw[gi];
                    sync2_reg <= sync1_reg;
                end
            end

            // Debouncer: count consecutive synced samples that differ from the
            // accepted level; any return to the accepted level restarts the count.
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    count_reg <= '0;
                    level_reg <= 1'b0;
                end else if (sync2_reg == level_reg) begin
                    count_reg <= '0;
                end else if (count_reg == DB_LAST) begin
                    count_reg <= '0;
                    level_reg <= sync2_reg;
                end else begin
                    count_reg <= count_reg + DB_W'(1);
                end
            end

            assign level[gi] = level_reg;
        end
    endgenerate

    // Previous accepted level of the three adjust buttons, for rising-edge detection.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            level_d_reg <= '0;
        end else begin
            level_d_reg <= level[2:0];
        end
    end

    // One-cycle increment pulse per press; holding a button gives no repeat.
    assign inc_pulse = level[2:0] & ~level_d_reg;

    mode_t       state_reg;
    mode_t       state_next;
    logic [25:0] tick_reg;
    logic [25:0] tick_next;
    logic [5:0]  seconds_reg;
    logic [5:0]  seconds_next;
    logic [5:0]  minutes_reg;
    logic [5:0]  minutes_next;
    logic [4:0]  hours_reg;
    logic [4:0]  hours_next;
    logic        carry_s;
    logic        carry_m;

    // Mode state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= MODE_RUN;
        end else begin
            state_reg <= state_next;
        end
    end

    // Mode transitions follow the debounced switch; the prescaler runs only in RUN
    // and is held at zero in SET, so leaving SET always starts a full second.
    always_comb begin
        state_next = state_reg;
        tick_next  = '0;
        sec_pulse  = 1'b0;
        case (state_reg)
            MODE_RUN: begin
                if (level[3]) begin
                    state_next = MODE_SET;
                end
                if (tick_reg == TICK_LAST) begin
                    sec_pulse = 1'b1;
                end else begin
                    tick_next = tick_reg + 26'd1;
                end
            end
            MODE_SET: begin
                if (!level[3]) begin
                    state_next = MODE_RUN;
                end
            end
            default: begin
                state_next = MODE_RUN;
            end
        endcase
    end

    // Field updates: a manual pulse wins over the automatic path for its field and
    // suppresses that field's carry; compare-and-wrap keeps every field in range.
    always_comb begin
        carry_s = sec_pulse & ~inc_pulse[0] & (seconds_reg >= 6'd59);
        carry_m = carry_s & ~inc_pulse[1] & (minutes_reg >= 6'd59);

        seconds_next = seconds_reg;
        if (inc_pulse[0] | sec_pulse) begin
            seconds_next = (seconds_reg >= 6'd59) ? 6'd0 : seconds_reg + 6'd1;
        end

        minutes_next = minutes_reg;
        if (inc_pulse[1] | carry_s) begin
            minutes_next = (minutes_reg >= 6'd59) ? 6'd0 : minutes_reg + 6'd1;
        end

        hours_next = hours_reg;
        if (inc_pulse[2] | carry_m) begin
            hours_next = (hours_reg >= 5'd23) ? 5'd0 : hours_reg + 5'd1;
        end
    end

    // Prescaler and time-of-day registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tick_reg    <= '0;
            seconds_reg <= '0;
            minutes_reg <= '0;
            hours_reg   <= '0;
        end else begin
            tick_reg    <= tick_next;
            seconds_reg <= seconds_next;
            minutes_reg <= minutes_next;
            hours_reg   <= hours_next;
        end
    end

    assign tick    = tick_reg;
    assign seconds = seconds_reg;
    assign minutes = minutes_reg;
    assign hours   = hours_reg;

endmodule
